// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 binary-to-BCD converter, one bit per clock with start/busy/done handshake
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [WIDTH-1:0]             bin_in,
  output logic                         busy,
  output logic                         done,
  output logic [4*DIGITS-1:0]          bcd_out,
  output logic [$clog2(DIGITS+1)-1:0]  ndigits
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int NW = $clog2(DIGITS + 1);
  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction
  generate
    if (WIDTH < 1 || WIDTH > 32 || pow10(DIGITS) <= longint'((64'd1 << WIDTH) - 64'd1)) begin : g_bad_cfg
      $fatal(1, "bin_to_bcd_seq: WIDTH must be 1..32 and 10^DIGITS must exceed 2^WIDTH-1");
    end
  endgenerate
  typedef enum logic {IDLE, CONV} state_t;
  state_t           state, state_d;
  logic [WIDTH-1:0] bin_sr;
  logic [BW-1:0]    scratch, adj, shifted;
  logic [CW-1:0]    cnt;
  logic [NW-1:0]    nd;
  logic             last;
  assign last = cnt == CW'(1);
  always_comb begin
    adj = scratch;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k +: 4] = scratch[4*k +: 4] >= 4'd5 ? scratch[4*k +: 4] + 4'd3 : scratch[4*k +: 4];
    shifted = {adj[BW-2:0], bin_sr[WIDTH-1]};
    nd = NW'(1);
    for (int k = 0; k < DIGITS; k++)
      if (shifted[4*k +: 4] != 4'd0) nd = NW'(k + 1);
  end
  always_comb begin
    state_d = state == IDLE ? (start ? CONV : IDLE) : (last ? IDLE : CONV);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      ndigits <= '0;
    end else begin
      done <= state == CONV && last;
      busy <= state_d == CONV;
      if (state == IDLE && start) begin
        bin_sr  <= bin_in;
        scratch <= '0;
        cnt     <= CW'(WIDTH);
      end else if (state == CONV) begin
        bin_sr  <= bin_sr << 1;
        scratch <= shifted;
        cnt     <= cnt - CW'(1);
        if (last) begin
          bcd_out <= shifted;
          ndigits <= nd;
        end
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks of three converter configurations (8/3, 4/2, 16/5)
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0]  bin_a = '0;
  logic [3:0]  bin_b = '0;
  logic [15:0] bin_c = '0;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [19:0] bcd_c;
  logic [1:0]  nd_a, nd_b;
  logic [2:0]  nd_c;
  int checks = 0, passed = 0;
  int lat, bc, n;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_a (.clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .ndigits(nd_a));
  bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) u_b (.clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .ndigits(nd_b));
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_c (.clk(clk), .rst_n(rst_n), .start(start_c), .bin_in(bin_c),
    .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .ndigits(nd_c));

  function automatic logic done_of(input int d);
    return d == 0 ? done_a : d == 1 ? done_b : done_c;
  endfunction
  function automatic logic busy_of(input int d);
    return d == 0 ? busy_a : d == 1 ? busy_b : busy_c;
  endfunction
  function automatic logic [31:0] bcd_of(input int d);
    return d == 0 ? 32'(bcd_a) : d == 1 ? 32'(bcd_b) : 32'(bcd_c);
  endfunction
  function automatic logic [31:0] nd_of(input int d);
    return d == 0 ? 32'(nd_a) : d == 1 ? 32'(nd_b) : 32'(nd_c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic run(input int d, input logic [31:0] v, output int lt, output int busy_cnt);
    start_a = d == 0; start_b = d == 1; start_c = d == 2;
    bin_a = v[7:0]; bin_b = v[3:0]; bin_c = v[15:0];
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    lt = 0;
    busy_cnt = 0;
    while (!done_of(d) && lt < 100) begin
      if (busy_of(d)) busy_cnt++;
      @(negedge clk);
      lt++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy_a), 32'd0);
    chk("rst done", 32'(done_a), 32'd0);
    chk("rst bcd", bcd_of(0), 32'h0);
    chk("rst nd", nd_of(0), 32'd0);
    chk("rst nd16", nd_of(2), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 255, lat, bc);
    chk("255 latency", 32'(lat), 32'd8);
    chk("255 busy cycles", 32'(bc), 32'd8);
    chk("255 bcd", bcd_of(0), 32'h255);
    chk("255 nd", nd_of(0), 32'd3);
    @(negedge clk);
    chk("255 done one cycle", 32'(done_a), 32'd0);
    chk("255 held", bcd_of(0), 32'h255);

    run(0, 0, lat, bc);
    chk("0 bcd", bcd_of(0), 32'h000);
    chk("0 nd", nd_of(0), 32'd1);
    run(0, 9, lat, bc);
    chk("9 bcd", bcd_of(0), 32'h009);
    chk("9 nd", nd_of(0), 32'd1);
    run(0, 10, lat, bc);
    chk("10 bcd", bcd_of(0), 32'h010);
    chk("10 nd", nd_of(0), 32'd2);

    for (int v = 0; v < 16; v++) begin
      run(1, 32'(v), lat, bc);
      chk($sformatf("w4 %0d lat", v), 32'(lat), 32'd4);
      chk($sformatf("w4 %0d bcd", v), bcd_of(1), 32'(((v / 10) << 4) | (v % 10)));
      chk($sformatf("w4 %0d nd", v), nd_of(1), v >= 10 ? 32'd2 : 32'd1);
    end

    run(2, 65535, lat, bc);
    chk("65535 latency", 32'(lat), 32'd16);
    chk("65535 bcd", bcd_of(2), 32'h65535);
    chk("65535 nd", nd_of(2), 32'd5);
    run(2, 1000, lat, bc);
    chk("1000 bcd", bcd_of(2), 32'h01000);
    chk("1000 nd", nd_of(2), 32'd4);

    start_a = 1'b1; bin_a = 8'd123;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    start_a = 1'b1; bin_a = 8'd200;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("123 done seen", 32'(done_a), 32'd1);
    chk("123 ignores start", bcd_of(0), 32'h123);
    start_a = 1'b1; bin_a = 8'd45;
    @(negedge clk);
    start_a = 1'b0;
    n = 1;
    while (!done_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b spacing", 32'(n), 32'd9);
    chk("45 bcd", bcd_of(0), 32'h045);
    chk("45 nd", nd_of(0), 32'd2);

    start_a = 1'b1; bin_a = 8'd99;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid rst busy", 32'(busy_a), 32'd0);
    chk("mid rst bcd", bcd_of(0), 32'h0);
    chk("mid rst nd", nd_of(0), 32'd0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_a) n++;
    end
    chk("no done after rst", 32'(n), 32'd0);
    run(0, 77, lat, bc);
    chk("77 bcd", bcd_of(0), 32'h077);
    chk("77 nd", nd_of(0), 32'd2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
